// File: rtl/result_pkg.sv
// ============================================================================
// result_pkg
// Shared definitions for the result path: result word width, upstream mode
// encodings, and the helper that classifies modes for the capture policy.
// ============================================================================
package result_pkg;

    // Width of the result word produced by the upstream mux.
    localparam int unsigned RES_W  = 4;
    localparam int unsigned MODE_W = 2;

    // Upstream mux mode select.
    typedef enum logic [MODE_W-1:0] {
        MODE_ADD  = 2'b00,
        MODE_HOLD = 2'b01,
        MODE_CNT  = 2'b10,
        MODE_BAD  = 2'b11
    } mode_e;

    typedef logic [RES_W-1:0] res_t;

    // Adder and counter results are logged unconditionally.
    function automatic logic mode_always_captures(input mode_e mode);
        return (mode == MODE_ADD) || (mode == MODE_CNT);
    endfunction

endpackage : result_pkg

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO with a registered head output.
// The head word, valid, empty, full and level are all registered; a push into
// an empty FIFO is visible on rdata_o the cycle after the writing edge.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, clears pointers and level
//   push_i   : write wdata_i at the tail (ignored when full and not popping)
//   pop_i    : remove the head entry (ignored when empty)
//   wdata_i  : write data
//   rdata_o  : head entry, 0 when empty
//   valid_o  : FIFO non-empty
//   empty_o  : no entries
//   full_o   : level == DEPTH
//   level_o  : current entry count
// ============================================================================
module sync_fifo_fwft #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             valid_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [W-1:0]     rdata_q, rdata_d;
    logic             valid_q, empty_q, full_q;
    logic             do_pop, do_push;

    // Next-state for pointers, level and the registered head word.
    always_comb begin
        do_pop   = pop_i & ~empty_q;
        do_push  = push_i & (~full_q | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = '0;

        if (do_push) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
        end
        if (do_pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        end

        unique case ({do_push, do_pop})
            2'b10:   level_d = LVL_W'(level_q + LVL_W'(1));
            2'b01:   level_d = LVL_W'(level_q - LVL_W'(1));
            default: level_d = level_q;
        endcase

        // The next head is the word being written right now when the write
        // slot coincides with the next read slot (empty or level-1 pop).
        if (level_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[rd_ptr_d];
            end
        end
    end

    // State registers; storage is only written outside reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            valid_q  <= (level_d != '0);
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == LVL_W'(DEPTH));
        end
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule : sync_fifo_fwft

// File: rtl/result_logger.sv
// ============================================================================
// result_logger
// Logs results from the adder/counter/hold mux into an FWFT FIFO using a
// per-mode capture policy, keeps a saturating running sum of logged values,
// a sticky overflow flag and a one-cycle illegal-mode error pulse.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : result word from the upstream mux
//   din_valid  : din/sel qualify this cycle
//   sel        : upstream mode (00 adder, 10 counter, 01 hold, 11 illegal)
//   rd_en      : pop request from the consumer
//   dout       : oldest entry, 0 when empty
//   dout_valid : FIFO non-empty
//   empty      : no entries
//   full       : level == DEPTH
//   level      : entry count
//   sum        : saturating sum of every logged value
//   overflow   : sticky, a capture was dropped because the FIFO was full
//   err        : one-cycle pulse after a valid word with the illegal mode
// ============================================================================
module result_logger
    import result_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned SUM_W = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RES_W-1:0]  din,
    input  logic              din_valid,
    input  logic [MODE_W-1:0] sel,
    input  logic              rd_en,
    output logic [RES_W-1:0]  dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    output logic [SUM_W-1:0]  sum,
    output logic              overflow,
    output logic              err
);

    mode_e            mode;
    res_t             last_cap_q, last_cap_d;
    logic             last_ok_q, last_ok_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;
    logic [SUM_W:0]   sum_wide;
    logic             hold_new;
    logic             cap;
    logic             push;
    logic             fifo_full;

    assign mode = mode_e'(sel);

    // Capture policy, push qualification, sum and flag next-state.
    always_comb begin
        last_cap_d = last_cap_q;
        last_ok_d  = last_ok_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        err_d      = 1'b0;

        // Hold mode suppresses repeats of the last logged value from any mode.
        hold_new = ~last_ok_q | (din != last_cap_q);
        cap      = din_valid &
                   (mode_always_captures(mode) | ((mode == MODE_HOLD) & hold_new));
        // A concurrent pop frees a slot, so a full FIFO still accepts the word.
        push     = cap & (~fifo_full | rd_en);
        sum_wide = (SUM_W + 1)'(sum_q) + (SUM_W + 1)'(din);

        if (din_valid && (mode == MODE_BAD)) begin
            err_d = 1'b1;
        end

        if (push) begin
            last_cap_d = din;
            last_ok_d  = 1'b1;
            sum_d      = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
        end else if (cap) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_cap_q <= '0;
            last_ok_q  <= 1'b0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            last_cap_q <= last_cap_d;
            last_ok_q  <= last_ok_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .W     (RES_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (rd_en),
        .wdata_i (din),
        .rdata_o (dout),
        .valid_o (dout_valid),
        .empty_o (empty),
        .full_o  (fifo_full),
        .level_o (level)
    );

    assign full     = fifo_full;
    assign sum      = sum_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule : result_logger
